// File: rtl/flash_audio_streamer.sv
// Streams audio samples from an Avalon-MM flash through a word prefetch FIFO.
// Optional: define FLASH_STREAM_UNDERRUN_CNT_EN to add the underrun_count output.
module flash_audio_streamer #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SAMPLE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [22:0]         start_addr,
  input  logic [22:0]         end_addr,
  input  logic                reverse,
  input  logic                loop_en,
  input  logic                pause,
  input  logic                stop,
  input  logic                sample_tick,
  output logic                flash_mem_read,
  output logic                flash_mem_write,
  output logic [22:0]         flash_mem_address,
  output logic [5:0]          flash_mem_burstcount,
  output logic [3:0]          flash_mem_byteenable,
  output logic [31:0]         flash_mem_writedata,
  input  logic                flash_mem_waitrequest,
  input  logic                flash_mem_readdatavalid,
  input  logic [31:0]         flash_mem_readdata,
  output logic [SAMPLE_W-1:0] audio_output,
  output logic                audio_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_count
`endif
);

  localparam int unsigned SPW = 32 / SAMPLE_W;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned IW  = (SPW > 1) ? $clog2(SPW) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [23:0] BurstMax = 24'(BURST_LEN);

  logic [1:0]          state_q, state_d;
  logic [22:0]         cur_q, cur_d;
  logic [22:0]         first_q, first_d;
  logic [22:0]         last_q, last_d;
  logic                rev_q, rev_d;
  logic                loop_q, loop_d;
  logic                rd_q, rd_d;
  logic [22:0]         addr_q, addr_d;
  logic [5:0]          bc_q, bc_d;
  logic [5:0]          left_q, left_d;
  logic                discard_q, discard_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] aout_q, aout_d;
  logic                avalid_q, avalid_d;
  logic                wvalid_q, wvalid_d;
  logic [31:0]         word_q, word_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         cnt_q, cnt_d;

`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
  logic [15:0]         ucnt_q, ucnt_d;
`endif

  logic                start_ok, abort, beat, last_beat, range_last, space_ok, take_req;
  logic                avail, push, pop, pending;
  logic [23:0]         rem;
  logic [5:0]          bc_calc;
  logic [22:0]         next_cur;
  logic [15:0]         free16;
  logic [31:0]         head, src_word, shifted;
  logic [IW-1:0]       sel;
  logic [SAMPLE_W-1:0] sample;

  assign start_ok = start && (start_addr <= end_addr);
  // A restart or stop always flushes; the in-flight burst is drained separately.
  assign abort    = stop || start_ok;

  assign rem      = {1'b0, last_q} - {1'b0, cur_q} + 24'd1;
  assign bc_calc  = rev_q ? 6'd1 : ((rem < BurstMax) ? rem[5:0] : BurstMax[5:0]);
  assign free16   = 16'(FIFO_DEPTH) - 16'(cnt_q);
  assign space_ok = free16 >= 16'(bc_calc);

  assign beat       = flash_mem_readdatavalid && (state_q == StWait);
  assign last_beat  = beat && (left_q == 6'd1);
  assign range_last = rev_q ? (cur_q == first_q) : (rem == 24'(bc_q));
  assign next_cur   = rev_q ? (range_last ? last_q : cur_q - 23'd1)
                            : (range_last ? first_q : cur_q + 23'(bc_q));

  assign head     = mem[rptr_q];
  assign src_word = wvalid_q ? word_q : head;
  assign avail    = wvalid_q || (cnt_q != '0);
  assign sel      = rev_q ? (IW'(SPW - 1) - idx_q) : idx_q;
  assign shifted  = src_word >> (32'(sel) * SAMPLE_W);
  assign sample   = shifted[SAMPLE_W-1:0];
  assign take_req = sample_tick && !pause && busy_q;

  assign push    = beat && !discard_q && !abort;
  // The holding word register refills from the FIFO head whenever it is empty.
  assign pop     = !abort && !wvalid_q && (cnt_q != '0);
  assign pending = ((state_q == StIssue) && rd_q) || ((state_q == StWait) && !last_beat);
  assign cnt_d   = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    first_d    = first_q;
    last_d     = last_q;
    rev_d      = rev_q;
    loop_d     = loop_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    bc_d       = bc_q;
    left_d     = left_q;
    discard_d  = discard_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    aout_d     = aout_q;
    avalid_d   = 1'b0;
    wvalid_d   = wvalid_q || pop;
    word_d     = pop ? head : word_q;
    idx_d      = idx_q;
`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
    ucnt_d     = ucnt_q;
`endif

    case (state_q)
      StIssue: begin
        if (!rd_q) begin
          if (space_ok) begin
            rd_d   = 1'b1;
            addr_d = cur_q;
            bc_d   = bc_calc;
          end
        end else if (!flash_mem_waitrequest) begin
          rd_d    = 1'b0;
          left_d  = bc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (beat) begin
          left_d = left_q - 6'd1;
          if (left_q == 6'd1) begin
            if (discard_q) begin
              // busy still high here means a restart is waiting for the drain.
              discard_d = 1'b0;
              state_d   = busy_q ? StIssue : StIdle;
            end else if (range_last && !loop_q) begin
              state_d = StDrain;
            end else begin
              state_d = StIssue;
              cur_d   = next_cur;
            end
          end
        end
      end
      default: ;
    endcase

    if (take_req) begin
      if (avail) begin
        aout_d   = sample;
        avalid_d = 1'b1;
        if (idx_q == IW'(SPW - 1)) begin
          idx_d    = '0;
          wvalid_d = 1'b0;
          if ((state_q == StDrain) && (cnt_q == '0)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else if (!discard_q) begin
        underrun_d = 1'b1;
`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
      end
    end

    if (abort) begin
      wvalid_d = 1'b0;
      idx_d    = '0;
      avalid_d = 1'b0;
      aout_d   = aout_q;
      done_d   = 1'b0;
      if (pending) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
        rd_d      = 1'b0;
        state_d   = start_ok ? StIssue : StIdle;
      end
      if (start_ok) begin
        first_d    = start_addr;
        last_d     = end_addr;
        rev_d      = reverse;
        loop_d     = loop_en;
        cur_d      = reverse ? end_addr : start_addr;
        busy_d     = 1'b1;
        underrun_d = 1'b0;
`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
        ucnt_d     = 16'd0;
`endif
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
      rev_q      <= 1'b0;
      loop_q     <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      bc_q       <= '0;
      left_q     <= '0;
      discard_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      aout_q     <= '0;
      avalid_q   <= 1'b0;
      wvalid_q   <= 1'b0;
      word_q     <= '0;
      idx_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      first_q    <= first_d;
      last_q     <= last_d;
      rev_q      <= rev_d;
      loop_q     <= loop_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      bc_q       <= bc_d;
      left_q     <= left_d;
      discard_q  <= discard_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      aout_q     <= aout_d;
      avalid_q   <= avalid_d;
      wvalid_q   <= wvalid_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      if (abort) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= flash_mem_readdata;
  end

`ifdef FLASH_STREAM_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= 16'd0;
    else     ucnt_q <= ucnt_d;
  end
  assign underrun_count = ucnt_q;
`endif

  assign flash_mem_read       = rd_q;
  assign flash_mem_write      = 1'b0;
  assign flash_mem_address    = addr_q;
  assign flash_mem_burstcount = bc_q;
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_writedata  = 32'h0;
  assign audio_output         = aout_q;
  assign audio_valid          = avalid_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign underrun             = underrun_q;

endmodule

// File: doc/flash_audio_streamer.md
FLASH_AUDIO_STREAMER -- requirements
Module: flash_audio_streamer

Interface
REQ-001 Parameter BURST_LEN, default 4: maximum words per forward burst, power of two, 1..32.
REQ-002 Parameter FIFO_DEPTH, default 16: word prefetch FIFO depth, power of two, >= 2*BURST_LEN.
REQ-003 Parameter SAMPLE_W, default 8: audio sample width, 8 or 16; SPW = 32/SAMPLE_W samples per word.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; latches start_addr/end_addr/reverse/loop_en and begins playback.
REQ-007 start_addr, end_addr  in  23 each  inclusive word-address range; start_addr <= end_addr.
REQ-008 reverse  in  1  1 = play end_addr down to start_addr, samples within a word high-to-low.
REQ-009 loop_en  in  1  1 = wrap to the range's first word after its last word.
REQ-010 pause  in  1  level; while high, sample_tick is ignored (prefetch continues).
REQ-011 stop  in  1  one-cycle pulse; aborts playback.
REQ-012 sample_tick  in  1  one-cycle strobe requesting the next sample.
REQ-013 flash_mem_read, flash_mem_write  out  1 each  Avalon-MM read strobe; write tied 0.
REQ-014 flash_mem_address  out  23; flash_mem_burstcount  out  6; flash_mem_byteenable  out  4 (tied 4'hF); flash_mem_writedata  out  32 (tied 0).
REQ-015 flash_mem_waitrequest, flash_mem_readdatavalid  in  1 each; flash_mem_readdata  in  32.
REQ-016 audio_output  out  SAMPLE_W  current sample; audio_valid  out  1  one-cycle pulse per updated sample.
REQ-017 busy  out  1  playback active; done  out  1  one-cycle pulse at non-loop completion; underrun  out  1  sticky.

Function
REQ-018 Request FSM states: IDLE, ISSUE, WAIT_DATA, DRAIN; IDLE->ISSUE on start.
REQ-019 ISSUE: enter only when FIFO free space (including outstanding words) >= burstcount; hold read/address/burstcount stable until waitrequest low, then go to WAIT_DATA.
REQ-020 Forward burstcount = min(BURST_LEN, end_addr - cur_addr + 1); reverse burstcount = 1, address decrements by 1.
REQ-021 WAIT_DATA: push each word with readdatavalid into the FIFO; after burstcount words, advance address, then ISSUE, or DRAIN once the last range word is requested and loop_en = 0.
REQ-022 With loop_en = 1, the address after the last word wraps to the first word with no gap cycle; DRAIN is never entered.
REQ-023 Playback side: on sample_tick with pause low and data present, audio_output takes the next sample and audio_valid pulses the next cycle (1-cycle latency).
REQ-024 Sample order: forward = bits [SAMPLE_W-1:0] first; reverse = bits [31:32-SAMPLE_W] first; FIFO pops after the SPW-th sample.
REQ-025 Underrun: sample_tick with pause low, busy high and the FIFO plus current word empty -> audio_output holds, no audio_valid, underrun set (cleared only by start or rst).
REQ-026 DRAIN: when the final sample is output, done pulses, busy drops, FSM returns to IDLE.
REQ-027 stop, or start while busy: terminate any pending request by completing its outstanding beats (readdatavalid beats discarded), flush FIFO, then IDLE (or restart for start); audio_output holds its last value.
REQ-028 Simultaneous FIFO push and pop in one cycle: both occur; occupancy unchanged.
REQ-029 start with start_addr > end_addr: ignored, busy stays 0.

Reset
REQ-030 rst forces IDLE, empty FIFO, flash_mem_read=0, address=0, burstcount=0, audio_output=0, audio_valid=0, busy=0, done=0, underrun=0.
REQ-031 rst mid-burst: discards data beats, issues no new request for 1 cycle after deassertion.

Configuration
REQ-032 FLASH_STREAM_UNDERRUN_CNT_EN defined: adds output underrun_count [15:0], incremented per underrun event, saturating at 16'hFFFF, cleared by rst/start.
REQ-033 Macro undefined: port absent, no counter logic; all other behaviour identical.

Verification
REQ-034 Forward, SAMPLE_W=8, range 0x10..0x11, data 0x44332211/0x88776655, ticks every 8 cycles -> outputs 11,22,...,88; done pulse; one burst with burstcount 2.
REQ-035 Reverse, same data -> outputs 88,77,...,11; two single-word reads at 0x11 then 0x10.
REQ-036 loop_en=1, range of 1 word, 10 ticks -> samples repeat every SPW; done never pulses; busy stays 1.
REQ-037 waitrequest held high 50 cycles, ticks every 4 cycles -> underrun=1, audio_output holds; counter (macro on) = missed ticks.
REQ-038 stop mid-burst of 4 with 2 beats delivered -> remaining 2 beats absorbed, FIFO empty, busy=0 within 3 cycles of last beat.
REQ-039 rst asserted while ISSUE -> next cycle all outputs at REQ-030 values.
